mc_ctrl_hs: RTL and testbench

//  Next-generation multicycle control FSM for the 16-bit datapath. It decodes op/op_ext, evaluates branch conditions against the PSR, and drives the datapath mux selects and enables.

---
 rtl/mc_ctrl_hs_if.sv | 45 ++++
 rtl/mc_ctrl_hs.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_hs_if.sv
// Control bundle between the instruction register/PSR, the memory port and
// the datapath control inputs of the multicycle controller.
// The controller uses the slave modport; the environment uses master.
interface mc_ctrl_hs_if;
   // Instruction, status and handshake inputs to the controller
   logic [3:0] op;
   logic [3:0] op_ext;
   logic [3:0] branch_cond;
   logic [4:0] psr;
   logic       mem_ack;
   logic       halt_req;

   // Datapath control outputs of the controller
   logic [1:0] wd_s;
   logic [1:0] alua_s;
   logic [1:0] alub_s;
   logic       pc_s;
   logic       pc_en;
   logic       reg_wr_en;
   logic       instr_en;
   logic       alu_out_en;
   logic       mem_reg_en;
   logic       mem_wr;
   logic       mem_s;
   logic       mem_req;
   logic       se_sign;
   logic       psr_en;
   logic       retire;
   logic       halted;
   logic       fault;

   modport master (
      output op, op_ext, branch_cond, psr, mem_ack, halt_req,
      input  wd_s, alua_s, alub_s, pc_s, pc_en, reg_wr_en, instr_en,
             alu_out_en, mem_reg_en, mem_wr, mem_s, mem_req, se_sign,
             psr_en, retire, halted, fault
   );

   modport slave (
      input  op, op_ext, branch_cond, psr, mem_ack, halt_req,
      output wd_s, alua_s, alub_s, pc_s, pc_en, reg_wr_en, instr_en,
             alu_out_en, mem_reg_en, mem_wr, mem_s, mem_req, se_sign,
             psr_en, retire, halted, fault
   );
endinterface

// File: rtl/mc_ctrl_hs.sv
// Multicycle control FSM for the 16-bit datapath with a req/ack handshake on
// every memory access, a bounded wait that ends in a sticky FAULT, a halt
// mode taken at instruction boundaries and a one-cycle retire pulse.
module mc_ctrl_hs #(
   parameter int MEM_HS     = 1,
   parameter int WAIT_LIMIT = 15,
   parameter int WCNT_W     = 4
) (
   input logic         clk,
   input logic         reset,
   mc_ctrl_hs_if.slave bus
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_R_EX      = 4'd2,
      S_I_EX      = 4'd3,
      S_WRITE     = 4'd4,
      S_LD_MEM    = 4'd5,
      S_LD_WB     = 4'd6,
      S_ST_MEM    = 4'd7,
      S_BR_DISP   = 4'd8,
      S_JUMP      = 4'd9,
      S_LINK_CALC = 4'd10,
      S_LINK_WR   = 4'd11,
      S_PC_UP     = 4'd12,
      S_HALTED    = 4'd13,
      S_FAULT     = 4'd14
   } state_t;

   // Registered control word. fetch_cyc/load_cyc mark the memory states
   // whose register loads are only qualified by the ack of that cycle.
   typedef struct packed {
      logic [1:0] wd_s;
      logic [1:0] alua_s;
      logic [1:0] alub_s;
      logic       pc_s;
      logic       pc_en;
      logic       reg_wr_en;
      logic       fetch_cyc;
      logic       alu_out_en;
      logic       load_cyc;
      logic       mem_wr;
      logic       mem_s;
      logic       mem_req;
      logic       se_sign;
      logic       psr_en;
      logic       retire;
      logic       halted;
      logic       fault;
   } ctrl_t;

   localparam logic [WCNT_W-1:0] WLIM = WCNT_W'(WAIT_LIMIT);

   state_t            state_reg;
   state_t            state_next;
   logic [WCNT_W-1:0] wait_cnt_reg;
   logic [WCNT_W-1:0] wait_cnt_next;
   logic [WCNT_W-1:0] wait_cnt_inc;
   logic              wait_at_limit;
   ctrl_t             ctrl_reg;
   ctrl_t             ctrl_out;
   logic              ack_eff;
   logic [15:0]       cond_vec;
   logic              cond_true;
   logic              psr_n;
   logic              psr_z;
   logic              psr_f;
   logic              psr_l;
   logic              psr_c;

   // Without the handshake every memory state completes in its first cycle
   if (MEM_HS != 0) begin : g_hs
      assign ack_eff = bus.mem_ack;
   end else begin : g_no_hs
      assign ack_eff = 1'b1;
   end

   assign psr_n = bus.psr[4];
   assign psr_z = bus.psr[3];
   assign psr_f = bus.psr[2];
   assign psr_l = bus.psr[1];
   assign psr_c = bus.psr[0];

   // Truth of all sixteen condition codes, indexed by the condition field
   assign cond_vec = {
      1'b0,              // 1111 never
      1'b1,              // 1110 UC
      psr_n | psr_z,     // 1101 GE
      ~psr_n & ~psr_z,   // 1100 LT
      psr_l | psr_z,     // 1011 HS
      ~psr_l & ~psr_z,   // 1010 LO
      ~psr_f,            // 1001 FC
      psr_f,             // 1000 FS
      ~psr_n,            // 0111 LE
      psr_n,             // 0110 GT
      ~psr_l,            // 0101 LS
      psr_l,             // 0100 HI
      ~psr_c,            // 0011 CC
      psr_c,             // 0010 CS
      ~psr_z,            // 0001 NE
      psr_z              // 0000 EQ
   };
   assign cond_true = cond_vec[bus.branch_cond];

   // Saturating wait count; a count of WLIM without ack is the last chance
   assign wait_cnt_inc  = (wait_cnt_reg == {WCNT_W{1'b1}}) ? wait_cnt_reg
                                                           : wait_cnt_reg + WCNT_W'(1);
   assign wait_at_limit = (wait_cnt_reg >= WLIM);

   function automatic ctrl_t idle_ctrl();
      ctrl_t c;
      c         = '0;
      c.se_sign = 1'b1;
      return c;
   endfunction

   // Moore control word of a state; op only matters for I_EX extension
   function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] op_i);
      ctrl_t c;
      c = idle_ctrl();
      case (s)
         S_FETCH: begin
            c.mem_req   = 1'b1;
            c.mem_s     = 1'b1;
            c.fetch_cyc = 1'b1;
         end
         S_R_EX: begin
            c.alu_out_en = 1'b1;
            c.psr_en     = 1'b1;
         end
         S_I_EX: begin
            c.alu_out_en = 1'b1;
            c.psr_en     = 1'b1;
            c.alua_s     = 2'b10;
            c.se_sign    = !(op_i == 4'b0001 || op_i == 4'b0010 ||
                             op_i == 4'b0011 || op_i == 4'b1101);
         end
         S_WRITE: begin
            c.wd_s      = 2'b11;
            c.reg_wr_en = 1'b1;
         end
         S_LD_MEM: begin
            c.mem_req  = 1'b1;
            c.load_cyc = 1'b1;
         end
         S_LD_WB: begin
            c.wd_s      = 2'b10;
            c.reg_wr_en = 1'b1;
         end
         S_ST_MEM: begin
            c.mem_req = 1'b1;
            c.mem_wr  = 1'b1;
         end
         S_PC_UP: begin
            c.alua_s = 2'b01;
            c.alub_s = 2'b10;
            c.pc_s   = 1'b1;
            c.pc_en  = 1'b1;
            c.retire = 1'b1;
         end
         S_BR_DISP: begin
            c.alua_s = 2'b01;
            c.alub_s = 2'b01;
            c.pc_s   = 1'b1;
            c.pc_en  = 1'b1;
            c.retire = 1'b1;
         end
         S_JUMP: begin
            c.pc_en  = 1'b1;
            c.retire = 1'b1;
         end
         S_LINK_CALC: begin
            c.alua_s     = 2'b01;
            c.alu_out_en = 1'b1;
         end
         S_LINK_WR: begin
            c.wd_s      = 2'b11;
            c.reg_wr_en = 1'b1;
            c.pc_en     = 1'b1;
            c.retire    = 1'b1;
         end
         S_HALTED: c.halted = 1'b1;
         S_FAULT:  c.fault  = 1'b1;
         default:  ;
      endcase
      return c;
   endfunction

   // Next state and wait count from the current state and inputs
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = '0;
      case (state_reg)
         S_FETCH: begin
            if (ack_eff) begin
               state_next = S_DECODE;
            end else if (wait_at_limit) begin
               state_next = S_FAULT;
            end else begin
               wait_cnt_next = wait_cnt_inc;
            end
         end
         S_DECODE: begin
            case (bus.op)
               4'b0000: state_next = S_R_EX;
               4'b1100: state_next = cond_true ? S_BR_DISP : S_PC_UP;
               4'b0100: begin
                  case (bus.op_ext)
                     4'b0000: state_next = S_LD_MEM;
                     4'b0100: state_next = S_ST_MEM;
                     4'b1000: state_next = S_LINK_CALC;
                     4'b1100: state_next = cond_true ? S_JUMP : S_PC_UP;
                     default: state_next = S_FAULT;
                  endcase
               end
               default: state_next = S_I_EX;
            endcase
         end
         // Compares only update the PSR, so they skip the write-back
         S_R_EX:  state_next = (bus.op_ext == 4'b1011) ? S_PC_UP : S_WRITE;
         S_I_EX:  state_next = (bus.op == 4'b1011) ? S_PC_UP : S_WRITE;
         S_WRITE: state_next = S_PC_UP;
         S_LD_MEM: begin
            if (ack_eff) begin
               state_next = S_LD_WB;
            end else if (wait_at_limit) begin
               state_next = S_FAULT;
            end else begin
               wait_cnt_next = wait_cnt_inc;
            end
         end
         S_LD_WB: state_next = S_PC_UP;
         S_ST_MEM: begin
            if (ack_eff) begin
               state_next = S_PC_UP;
            end else if (wait_at_limit) begin
               state_next = S_FAULT;
            end else begin
               wait_cnt_next = wait_cnt_inc;
            end
         end
         S_LINK_CALC: state_next = S_LINK_WR;
         // Instruction boundary: halt_req is only looked at here
         S_PC_UP, S_BR_DISP, S_JUMP, S_LINK_WR:
            state_next = bus.halt_req ? S_HALTED : S_FETCH;
         S_HALTED: state_next = bus.halt_req ? S_HALTED : S_FETCH;
         S_FAULT:  state_next = S_FAULT;
         default:  state_next = S_FAULT;
      endcase
   end

   // State, wait count and the registered control word of the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_FETCH;
         wait_cnt_reg <= '0;
         ctrl_reg     <= decode_ctrl(S_FETCH, bus.op);
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         ctrl_reg     <= decode_ctrl(state_next, bus.op);
      end
   end

   // Outputs fall to their idle values for as long as reset is held
   always_comb begin
      ctrl_out = ctrl_reg;
      if (reset) begin
         ctrl_out = idle_ctrl();
      end
   end

   assign bus.wd_s       = ctrl_out.wd_s;
   assign bus.alua_s     = ctrl_out.alua_s;
   assign bus.alub_s     = ctrl_out.alub_s;
   assign bus.pc_s       = ctrl_out.pc_s;
   assign bus.pc_en      = ctrl_out.pc_en;
   assign bus.reg_wr_en  = ctrl_out.reg_wr_en;
   assign bus.instr_en   = ctrl_out.fetch_cyc & ack_eff;
   assign bus.alu_out_en = ctrl_out.alu_out_en;
   assign bus.mem_reg_en = ctrl_out.load_cyc & ack_eff;
   assign bus.mem_wr     = ctrl_out.mem_wr;
   assign bus.mem_s      = ctrl_out.mem_s;
   assign bus.mem_req    = ctrl_out.mem_req;
   assign bus.se_sign    = ctrl_out.se_sign;
   assign bus.psr_en     = ctrl_out.psr_en;
   assign bus.retire     = ctrl_out.retire;
   assign bus.halted     = ctrl_out.halted;
   assign bus.fault      = ctrl_out.fault;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Randomized bench for mc_ctrl_hs. Each instruction is expanded into a
// per-cycle script of inputs and expected outputs from its class, memory
// latencies and halt choice, then replayed against the controller.
module tb_mc_ctrl_hs;
   localparam int WAIT_LIMIT = 15;

   logic clk = 1'b0;
   logic reset;

   mc_ctrl_hs_if bus_if ();

   mc_ctrl_hs #(
      .MEM_HS     (1),
      .WAIT_LIMIT (WAIT_LIMIT),
      .WCNT_W     (4)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] wd_s;
      logic [1:0] alua_s;
      logic [1:0] alub_s;
      logic       pc_s;
      logic       pc_en;
      logic       reg_wr_en;
      logic       instr_en;
      logic       alu_out_en;
      logic       mem_reg_en;
      logic       mem_wr;
      logic       mem_s;
      logic       mem_req;
      logic       se_sign;
      logic       psr_en;
      logic       retire;
      logic       halted;
      logic       fault;
   } obs_t;

   typedef struct {
      logic  ack;
      logic  halt;
      obs_t  exp;
      string tag;
   } step_t;

   step_t script[$];
   int    retire_idx;
   int    n_vectors     = 0;
   int    n_miscompares = 0;

   task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.wd_s       = bus_if.wd_s;
      o.alua_s     = bus_if.alua_s;
      o.alub_s     = bus_if.alub_s;
      o.pc_s       = bus_if.pc_s;
      o.pc_en      = bus_if.pc_en;
      o.reg_wr_en  = bus_if.reg_wr_en;
      o.instr_en   = bus_if.instr_en;
      o.alu_out_en = bus_if.alu_out_en;
      o.mem_reg_en = bus_if.mem_reg_en;
      o.mem_wr     = bus_if.mem_wr;
      o.mem_s      = bus_if.mem_s;
      o.mem_req    = bus_if.mem_req;
      o.se_sign    = bus_if.se_sign;
      o.psr_en     = bus_if.psr_en;
      o.retire     = bus_if.retire;
      o.halted     = bus_if.halted;
      o.fault      = bus_if.fault;
      return o;
   endfunction

   function automatic obs_t idle();
      obs_t o;
      o         = '0;
      o.se_sign = 1'b1;
      return o;
   endfunction

   function automatic logic rnd();
      return logic'($urandom % 2);
   endfunction

   function automatic void push(input logic ack, input logic halt, input obs_t e, input string tag);
      step_t s;
      s.ack  = ack;
      s.halt = halt;
      s.exp  = e;
      s.tag  = tag;
      script.push_back(s);
   endfunction

   // Condition table: N=psr[4] Z=psr[3] F=psr[2] L=psr[1] C=psr[0]
   function automatic logic cond_holds(input logic [3:0] cc, input logic [4:0] p);
      logic n, z, f, l, c;
      {n, z, f, l, c} = p;
      case (cc)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return l;
         4'd5:  return !l;
         4'd6:  return n;
         4'd7:  return !n;
         4'd8:  return f;
         4'd9:  return !f;
         4'd10: return !l && !z;
         4'd11: return l || z;
         4'd12: return !n && !z;
         4'd13: return n || z;
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void push_fault();
      obs_t e;
      e       = idle();
      e.fault = 1'b1;
      for (int k = 0; k < 3; k++) push(rnd(), rnd(), e, "FAULT");
   endfunction

   // One memory access: kind 0 fetch, 1 load, 2 store. Returns 1 on timeout.
   function automatic bit mem_phase(input int kind, input int delay);
      obs_t  e;
      string tag;
      int    n_wait;
      tag    = (kind == 0) ? "FETCH" : (kind == 1) ? "LD_MEM" : "ST_MEM";
      n_wait = (delay > WAIT_LIMIT) ? WAIT_LIMIT + 1 : delay;
      e         = idle();
      e.mem_req = 1'b1;
      e.mem_s   = (kind == 0);
      e.mem_wr  = (kind == 2);
      for (int i = 0; i < n_wait; i++) push(1'b0, rnd(), e, tag);
      if (delay > WAIT_LIMIT) begin
         push_fault();
         return 1'b1;
      end
      e.instr_en   = (kind == 0);
      e.mem_reg_en = (kind == 1);
      push(1'b1, rnd(), e, tag);
      return 1'b0;
   endfunction

   function automatic void push_retire(input obs_t e, input string tag, input logic halt_sel, input int hc);
      obs_t h;
      retire_idx = script.size();
      e.retire   = 1'b1;
      push(rnd(), halt_sel, e, tag);
      if (halt_sel) begin
         h        = idle();
         h.halted = 1'b1;
         for (int i = 0; i < hc; i++) push(rnd(), (i < hc - 1), h, "HALTED");
      end
   endfunction

   function automatic obs_t pc_up_obs();
      obs_t e;
      e        = idle();
      e.alua_s = 2'b01;
      e.alub_s = 2'b10;
      e.pc_s   = 1'b1;
      e.pc_en  = 1'b1;
      return e;
   endfunction

   function automatic obs_t write_obs(input logic [1:0] src);
      obs_t e;
      e           = idle();
      e.wd_s      = src;
      e.reg_wr_en = 1'b1;
      return e;
   endfunction

   // Expected cycle script of one instruction; returns 1 if it ends in FAULT
   function automatic bit build(input logic [3:0] op, input logic [3:0] ext, input logic [3:0] cc,
                                input logic [4:0] p, input int df, input int dm,
                                input logic halt_sel, input int hc);
      obs_t e;
      script.delete();
      retire_idx = -1;
      if (mem_phase(0, df)) return 1'b1;
      push(rnd(), rnd(), idle(), "DECODE");
      if (op == 4'b0000 || !(op == 4'b0100 || op == 4'b1100)) begin
         e            = idle();
         e.alu_out_en = 1'b1;
         e.psr_en     = 1'b1;
         if (op != 4'b0000) begin
            e.alua_s  = 2'b10;
            e.se_sign = !(op inside {4'b0001, 4'b0010, 4'b0011, 4'b1101});
         end
         push(rnd(), rnd(), e, (op == 4'b0000) ? "R_EX" : "I_EX");
         if (!((op == 4'b0000 && ext == 4'b1011) || op == 4'b1011))
            push(rnd(), rnd(), write_obs(2'b11), "WRITE");
         push_retire(pc_up_obs(), "PC_UP", halt_sel, hc);
      end else if (op == 4'b1100) begin
         if (cond_holds(cc, p)) begin
            e        = pc_up_obs();
            e.alub_s = 2'b01;
            push_retire(e, "BR_DISP", halt_sel, hc);
         end else begin
            push_retire(pc_up_obs(), "PC_UP", halt_sel, hc);
         end
      end else begin
         case (ext)
            4'b0000: begin
               if (mem_phase(1, dm)) return 1'b1;
               push(rnd(), rnd(), write_obs(2'b10), "LD_WB");
               push_retire(pc_up_obs(), "PC_UP", halt_sel, hc);
            end
            4'b0100: begin
               if (mem_phase(2, dm)) return 1'b1;
               push_retire(pc_up_obs(), "PC_UP", halt_sel, hc);
            end
            4'b1000: begin
               e            = idle();
               e.alua_s     = 2'b01;
               e.alu_out_en = 1'b1;
               push(rnd(), rnd(), e, "LINK_CALC");
               e       = write_obs(2'b11);
               e.pc_en = 1'b1;
               push_retire(e, "LINK_WR", halt_sel, hc);
            end
            4'b1100: begin
               if (cond_holds(cc, p)) begin
                  e       = idle();
                  e.pc_en = 1'b1;
                  push_retire(e, "JUMP", halt_sel, hc);
               end else begin
                  push_retire(pc_up_obs(), "PC_UP", halt_sel, hc);
               end
            end
            default: begin
               push_fault();
               return 1'b1;
            end
         endcase
      end
      return 1'b0;
   endfunction

   // One reset cycle: outputs must be idle while reset is high
   task automatic do_reset(input string tag);
      reset           = 1'b1;
      bus_if.mem_ack  = rnd();
      bus_if.halt_req = rnd();
      @(negedge clk);
      check_eq(tag, sample(), idle());
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // abort: -1 none, -2 reset in the retire cycle, -3 reset at a random cycle
   task automatic run_instr(input logic [3:0] op, input logic [3:0] ext, input logic [3:0] cc,
                            input logic [4:0] p, input int df, input int dm,
                            input logic halt_sel, input int hc, input int abort);
      bit faulted;
      bit aborted;
      int idx;
      int cycles;
      faulted = build(op, ext, cc, p, df, dm, halt_sel, hc);
      aborted = 1'b0;
      cycles  = 0;
      idx     = abort;
      if (abort == -2) idx = retire_idx;
      if (abort == -3) idx = $urandom_range(script.size() - 1, 0);
      bus_if.op          = op;
      bus_if.op_ext      = ext;
      bus_if.branch_cond = cc;
      bus_if.psr         = p;
      for (int i = 0; i < script.size(); i++) begin
         if (i == idx) begin
            do_reset("RST_MID");
            aborted = 1'b1;
            break;
         end
         reset           = 1'b0;
         bus_if.mem_ack  = script[i].ack;
         bus_if.halt_req = script[i].halt;
         @(negedge clk);
         check_eq(script[i].tag, sample(), script[i].exp);
         @(posedge clk);
         #1;
         cycles++;
      end
      if (faulted && !aborted) do_reset("RST_FAULT");
      $display("instr op=%h ext=%h cc=%h psr=%b df=%0d dm=%0d halt=%0d cycles=%0d fault=%0d reset=%0d",
               op, ext, cc, p, df, dm, halt_sel, cycles, faulted, aborted);
   endtask

   function automatic int pick_delay();
      int r;
      r = $urandom_range(99, 0);
      if (r < 70) return $urandom_range(3, 0);
      if (r < 85) return $urandom_range(WAIT_LIMIT - 1, 4);
      if (r < 93) return WAIT_LIMIT;
      return WAIT_LIMIT + 1;
   endfunction

   initial begin
      logic [3:0] op;
      logic [3:0] ext;
      int         r;
      reset              = 1'b1;
      bus_if.op          = '0;
      bus_if.op_ext      = '0;
      bus_if.branch_cond = '0;
      bus_if.psr         = '0;
      bus_if.mem_ack     = 1'b0;
      bus_if.halt_req    = 1'b0;
      #1;
      do_reset("RESET");
      do_reset("RESET");

      // Directed cases
      run_instr(4'h5, 4'h0, 4'h0, 5'b00000, 3, 0, 1'b0, 1, -1);              // late fetch ack
      run_instr(4'h5, 4'h0, 4'h0, 5'b00000, 0, 0, 1'b0, 1, -1);              // ADDI
      run_instr(4'hC, 4'h0, 4'h0, 5'b01000, 0, 0, 1'b0, 1, -1);              // BEQ taken
      run_instr(4'hC, 4'h0, 4'h0, 5'b00000, 0, 0, 1'b0, 1, -1);              // BEQ not taken
      run_instr(4'h4, 4'h0, 4'h0, 5'b00000, 0, WAIT_LIMIT + 1, 1'b0, 1, -1); // load timeout
      run_instr(4'h4, 4'h0, 4'h0, 5'b00000, 0, WAIT_LIMIT, 1'b0, 1, -1);     // ack at limit
      run_instr(4'h4, 4'h4, 4'h0, 5'b00000, 0, 2, 1'b0, 1, -1);              // store
      run_instr(4'h5, 4'h0, 4'h0, 5'b00000, 0, 0, 1'b1, 3, -1);              // halt
      run_instr(4'h4, 4'h8, 4'h0, 5'b00000, 0, 0, 1'b0, 1, -2);              // JAL, reset in LINK_WR
      run_instr(4'h4, 4'hC, 4'hE, 5'b00000, 0, 0, 1'b0, 1, -1);              // JUMP UC
      run_instr(4'h4, 4'h3, 4'h0, 5'b00000, 0, 0, 1'b0, 1, -1);              // bad op_ext
      run_instr(4'h0, 4'hB, 4'h0, 5'b00000, 1, 0, 1'b0, 1, -1);              // CMP
      run_instr(4'h1, 4'h0, 4'h0, 5'b00000, 0, 0, 1'b0, 1, -1);              // zero-extend

      // Randomized instruction stream
      for (int n = 0; n < 400; n++) begin
         r   = $urandom_range(99, 0);
         op  = 4'($urandom);
         ext = 4'($urandom);
         if (r < 20) op = 4'b0000;
         else if (r < 45) begin
            op  = 4'b0100;
            if ($urandom_range(9, 0) != 0) ext = {2'($urandom), 2'b00};
         end else if (r < 60) op = 4'b1100;
         if ($urandom_range(3, 0) == 0) ext = 4'b1011;
         run_instr(op, ext, 4'($urandom), 5'($urandom), pick_delay(), pick_delay(),
                   ($urandom_range(4, 0) == 0), $urandom_range(4, 1),
                   ($urandom_range(19, 0) == 0) ? -3 : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule
